// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, centre sampling,
// optional parity, 1-2 stop bits, break detection.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        clk_q, clk_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 low_q, low_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_o_q, perr_o_d;
    logic                 ferr_o_q, ferr_o_d;
    logic                 brk_q, brk_d;
    logic                 rx;
    logic                 tick;

    assign rx   = sync_q[1];
    assign tick = (clk_q == FULL);

    always_ff @(posedge i_Clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_Clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            clk_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            low_q    <= 1'b0;
            dv_q     <= 1'b0;
            byte_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_RX_Serial};
            clk_q    <= clk_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            low_q    <= low_d;
            dv_q     <= dv_d;
            byte_q   <= byte_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            brk_q    <= brk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clk_d    = clk_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        low_d    = low_q;
        dv_d     = 1'b0;
        byte_d   = byte_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        brk_d    = brk_q;
        unique case (state_q)
            S_IDLE: begin
                clk_d = '0;
                bit_d = '0;
                if (!rx) state_d = S_START;
            end
            S_START: begin
                if (clk_q == HALF) begin
                    clk_d = '0;
                    if (!rx) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        low_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    clk_d   = '0;
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx;
                    low_d   = low_q & ~rx;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    clk_d   = '0;
                    low_d   = low_q & ~rx;
                    perr_d  = (PARITY == 1) ? ~(par_q ^ rx) : (par_q ^ rx);
                    state_d = S_STOP;
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    clk_d  = '0;
                    ferr_d = ferr_q | ~rx;
                    low_d  = low_q & ~rx;
                    if (bit_q == LAST_STOP) begin
                        // Publish the whole frame in one registered update.
                        bit_d    = '0;
                        dv_d     = 1'b1;
                        byte_d   = shift_q;
                        perr_o_d = (PARITY != 0) && perr_q;
                        ferr_o_d = ferr_q | ~rx;
                        brk_d    = low_q & ~rx;
                        state_d  = rx ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                clk_d = '0;
                if (rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy       = (state_q != S_IDLE);
        o_RX_DV      = dv_q;
        o_RX_Byte    = byte_q;
        o_Parity_Err = perr_o_q;
        o_Frame_Err  = ferr_o_q;
        o_Break      = brk_q;
    end

endmodule
